cnt_event_monitor: RTL and testbench

- Downstream consumer of the N-bit enabled counter's cnt output.
- Watches the count and detects two events:
  - wrap-around (2^N-1 -> 0)
  - compare match against a programmable value
- Events go into a small FIFO and are presented to a reporting agent over a valid/ready interface.
- Lost events are flagged by a sticky overflow bit and a saturating drop counter.

---
 rtl/cnt_event_monitor.sv | 119 +++++++++++
 tb/tb_cnt_event_monitor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_event_monitor.sv
// Event monitor for an N-bit counter: detects wrap and compare-match, queues events
// in a small FIFO for a valid/ready consumer, and tracks dropped events.
module cnt_event_monitor #(
    parameter int unsigned N     = 7,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  cnt,
    input  logic [N-1:0]  cmp_val,
    input  logic          cmp_en,
    input  logic          evt_ready,
    input  logic          ovf_clr,
    output logic          evt_valid,
    output logic [1:0]    evt_code,
    output logic [N-1:0]  evt_cnt,
    output logic          ovf,
    output logic [DW-1:0] drop_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [1:0]   code;
        logic [N-1:0] cnt;
    } evt_t;

    evt_t          mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  prev_cnt_q;
    logic          prev_vld_q;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] drop_q, drop_d;

    logic wrap_c, match_c, push_c, pop_c, full_c, accept_c, drop_c;
    evt_t push_evt_c;

    // Edge detection against the previous sample; blind until one sample exists.
    always_comb begin
        wrap_c     = prev_vld_q && (prev_cnt_q == {N{1'b1}}) && (cnt == '0);
        match_c    = prev_vld_q && cmp_en && (cnt == cmp_val) && (cnt != prev_cnt_q);
        push_c     = wrap_c || match_c;
        push_evt_c = '{code: {match_c, wrap_c}, cnt: cnt};
    end

    // FIFO bookkeeping and overflow tracking next-state.
    always_comb begin
        pop_c    = (count_q != '0) && evt_ready;
        full_c   = (count_q == CW'(DEPTH));
        accept_c = push_c && (!full_c || pop_c);
        drop_c   = push_c && full_c && !pop_c;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CW'(accept_c) - CW'(pop_c);
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (accept_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        // A drop in the same cycle as a clear leaves exactly that drop recorded.
        if (drop_c) begin
            ovf_d = 1'b1;
            if (ovf_clr) begin
                drop_d = DW'(1);
            end else if (drop_q != {DW{1'b1}}) begin
                drop_d = drop_q + DW'(1);
            end
        end else if (ovf_clr) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            prev_cnt_q <= '0;
            prev_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            prev_cnt_q <= cnt;
            prev_vld_q <= 1'b1;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    // Storage needs no reset: contents are only visible while occupancy is non-zero.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            mem_q[wr_ptr_q] <= push_evt_c;
        end
    end

    always_comb begin
        evt_valid = (count_q != '0);
        evt_code  = evt_valid ? mem_q[rd_ptr_q].code : 2'b00;
        evt_cnt   = evt_valid ? mem_q[rd_ptr_q].cnt  : '0;
        ovf       = ovf_q;
        drop_cnt  = drop_q;
    end

endmodule

// File: tb/tb_cnt_event_monitor.sv
// Scoreboard bench for cnt_event_monitor: directed counter sequences with
// hand-computed events queued as expectations and checked by a separate monitor.
module tb_cnt_event_monitor;

    localparam int unsigned N  = 7;
    localparam int unsigned DW = 8;

    typedef struct packed {
        logic [1:0]   code;
        logic [N-1:0] cnt;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [N-1:0]  cnt;
    logic [N-1:0]  cmp_val;
    logic          cmp_en;
    logic          evt_ready;
    logic          ovf_clr;
    logic          evt_valid;
    logic [1:0]    evt_code;
    logic [N-1:0]  evt_cnt;
    logic          ovf;
    logic [DW-1:0] drop_cnt;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    cnt_event_monitor #(.N(N), .DEPTH(4), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .cnt      (cnt),
        .cmp_val  (cmp_val),
        .cmp_en   (cmp_en),
        .evt_ready(evt_ready),
        .ovf_clr  (ovf_clr),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .evt_cnt  (evt_cnt),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_evt(input logic [1:0] code, input logic [N-1:0] c);
        exp_q.push_back('{code: code, cnt: c});
    endtask

    task automatic drive(input int c, input int cv);
        cnt     = N'(c);
        cmp_val = N'(cv);
    endtask

    // Monitor: a pop happens at the next posedge whenever valid and ready are both high.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event actual code=%0d cnt=%0d required=none at %0t",
                             evt_code, evt_cnt, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("evt_code", 32'(evt_code), 32'(mon_e.code));
                    check("evt_cnt", 32'(evt_cnt), 32'(mon_e.cnt));
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        cnt       = '0;
        cmp_val   = '0;
        cmp_en    = 1'b0;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        #2 rst = 1'b0;
        step(3);
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_code", 32'(evt_code), 0);
        check("rst_cnt", 32'(evt_cnt), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        rst = 1'b1;
        step(1);

        // Wrap with consumer ready.
        drive(125, 0); step(1);
        drive(126, 0); step(1);
        drive(127, 0); step(1);
        expect_evt(2'b01, 0);
        drive(0, 0);   step(1);
        check("wrap_valid_hi", 32'(evt_valid), 1);
        step(1);
        check("wrap_valid_lo", 32'(evt_valid), 0);

        // Match fires once while the counter holds.
        cmp_en = 1'b1;
        drive(4, 5); step(1);
        expect_evt(2'b10, 5);
        drive(5, 5); step(3);
        drive(6, 5); step(2);
        check("match_drained", 32'(evt_valid), 0);
        check("empty_code", 32'(evt_code), 0);
        check("empty_cnt", 32'(evt_cnt), 0);

        // Wrap and match together.
        drive(127, 0); step(1);
        expect_evt(2'b11, 0);
        drive(0, 0); step(2);
        check("both_drained", 32'(evt_valid), 0);

        // Backpressure: four kept, two dropped.
        evt_ready = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            drive(v, v);
            if (v <= 4) expect_evt(2'b10, N'(v));
            step(1);
        end
        check("bp_ovf", 32'(ovf), 1);
        check("bp_drop", 32'(drop_cnt), 2);
        check("bp_valid", 32'(evt_valid), 1);
        check("bp_head_cnt", 32'(evt_cnt), 1);
        check("bp_head_code", 32'(evt_code), 2);
        step(1);
        check("bp_head_stable", 32'(evt_cnt), 1);
        drive(7, 7);
        ovf_clr = 1'b1;
        step(1);
        check("clr_vs_drop_ovf", 32'(ovf), 1);
        check("clr_vs_drop_cnt", 32'(drop_cnt), 1);
        evt_ready = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("clr_ovf", 32'(ovf), 0);
        check("clr_drop", 32'(drop_cnt), 0);
        step(2);
        check("drain_3_left_1", 32'(evt_valid), 1);
        step(1);
        check("drain_consecutive", 32'(evt_valid), 0);

        // Full FIFO with simultaneous push and pop.
        evt_ready = 1'b0;
        for (int v = 8; v <= 11; v++) begin
            drive(v, v);
            expect_evt(2'b10, N'(v));
            step(1);
        end
        check("full_valid", 32'(evt_valid), 1);
        check("full_ovf", 32'(ovf), 0);
        evt_ready = 1'b1;
        drive(12, 12);
        expect_evt(2'b10, 12);
        step(1);
        check("pushpop_ovf", 32'(ovf), 0);
        check("pushpop_drop", 32'(drop_cnt), 0);
        step(3);
        check("pushpop_occ4", 32'(evt_valid), 1);
        step(1);
        check("pushpop_empty", 32'(evt_valid), 0);

        // Mid-operation reset discards queued entries.
        evt_ready = 1'b0;
        for (int v = 13; v <= 15; v++) begin
            drive(v, v);
            step(1);
        end
        check("pre_rst_valid", 32'(evt_valid), 1);
        drive(127, 15);
        step(1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(evt_valid), 0);
        check("async_rst_cnt", 32'(evt_cnt), 0);
        drive(0, 15);
        step(1);
        rst       = 1'b1;
        evt_ready = 1'b1;
        step(3);
        check("blind_wrap", 32'(evt_valid), 0);

        // First cycle after release must not report a match either.
        rst = 1'b0;
        drive(5, 5);
        step(1);
        rst = 1'b1;
        step(3);
        check("blind_match", 32'(evt_valid), 0);

        // Drop counter saturation.
        evt_ready = 1'b0;
        for (int i = 0; i < 260; i++) begin
            drive((i % 2) ? 21 : 20, (i % 2) ? 21 : 20);
            if (i < 4) expect_evt(2'b10, N'((i % 2) ? 21 : 20));
            step(1);
        end
        check("sat_drop", 32'(drop_cnt), 255);
        check("sat_ovf", 32'(ovf), 1);
        evt_ready = 1'b1;
        ovf_clr   = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        step(4);
        check("sat_drained", 32'(evt_valid), 0);
        check("sat_clr_drop", 32'(drop_cnt), 0);

        step(2);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
